// File: rtl/pico_pkg.sv
// Shared definitions for the pico core host side: data width, host FSM states
// and a small elaboration-time helper.
package pico_pkg;

  localparam int pico_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INT  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } host_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with first-word-through head output; DEPTH must be a
// power of two so the pointers wrap on their own.
module byte_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     n_rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [N-1:0]             data_i,
  output logic [N-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_level == (AW+1)'(DEPTH));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign data_o  = r_mem[r_rdPtr];

  // Guard both sides so a misbehaving caller can never corrupt the occupancy
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/core_host.sv
// Host-side driver for the pico core: queues upstream bytes, hands each to the
// core with an interrupt pulse, and latches the core's result when it halts.
module core_host
  import pico_pkg::*;
#(
  parameter int N        = pico_N,
  parameter int DEPTH    = 4,
  parameter int INT_HIGH = 2,
  parameter int HOLD     = 8
) (
  input  logic                   clk_i,
  input  logic                   n_rst_i,
  input  logic [N-1:0]           s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [N-1:0]           ext_data_o,
  output logic                   ext_int_o,
  input  logic                   halt_i,
  input  logic [N-1:0]           result_i,
  output logic [N-1:0]           result_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int CW = $clog2(max2(INT_HIGH, HOLD)) + 1;

  host_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_extData;
  logic          r_extInt;
  logic [N-1:0]  r_result;
  logic          r_done;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [N-1:0]  w_fifoData;

  assign s_ready_o = ~w_full & ~r_done;
  assign w_push    = s_valid_i & s_ready_o;
  // A halt in the same cycle as a pending byte wins: the byte stays queued
  assign w_pop     = (r_state == ST_IDLE) & ~w_empty & ~halt_i;

  byte_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (s_data_i),
    .data_o  (w_fifoData),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_extData <= '0;
      r_extInt  <= 1'b0;
      r_result  <= '0;
      r_done    <= 1'b0;
    end else if (halt_i && (r_state != ST_DONE)) begin
      r_state  <= ST_DONE;
      r_result <= result_i;
      r_done   <= 1'b1;
      r_extInt <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_extData <= w_fifoData;
            r_extInt  <= 1'b1;
            r_cnt     <= CW'(INT_HIGH - 1);
            r_state   <= ST_INT;
          end
        end
        ST_INT: begin
          if (r_cnt == '0) begin
            r_extInt <= 1'b0;
            r_cnt    <= CW'(HOLD - 1);
            r_state  <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_DONE;
        end
      endcase
    end
  end

  assign ext_data_o = r_extData;
  assign ext_int_o  = r_extInt;
  assign result_o   = r_result;
  assign done_o     = r_done;
  assign busy_o     = (r_state == ST_INT) || (r_state == ST_HOLD);

endmodule

// File: tb/tb_core_host.sv
// Bench for core_host: scenario tasks plus a negedge monitor that turns the
// ext_int_o waveform into a list of delivered bytes, pulse widths and gaps.
module tb_core_host;

  localparam int N        = 8;
  localparam int DEPTH    = 4;
  localparam int INT_HIGH = 2;
  localparam int HOLD     = 8;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nRst = 1'b0;
  logic [N-1:0]  sData = '0;
  logic          sValid = 1'b0;
  logic          sReady;
  logic [N-1:0]  extData;
  logic          extInt;
  logic          halt = 1'b0;
  logic [N-1:0]  resultIn = '0;
  logic [N-1:0]  resultOut;
  logic          done;
  logic          busy;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  // Monitor state: one entry per rising edge in obsQ/gapQ, one per falling edge in widthQ
  logic [N-1:0] obsQ[$];
  int           gapQ[$];
  int           widthQ[$];
  int           dataBad = 0;
  logic         prevInt = 1'b0;
  logic [N-1:0] prevData = '0;
  int           highRun = 0;
  int           lowRun = 0;
  logic         sawFall = 1'b0;

  always #5 clk = ~clk;

  core_host #(
    .N        (N),
    .DEPTH    (DEPTH),
    .INT_HIGH (INT_HIGH),
    .HOLD     (HOLD)
  ) dut (
    .clk_i      (clk),
    .n_rst_i    (nRst),
    .s_data_i   (sData),
    .s_valid_i  (sValid),
    .s_ready_o  (sReady),
    .ext_data_o (extData),
    .ext_int_o  (extInt),
    .halt_i     (halt),
    .result_i   (resultIn),
    .result_o   (resultOut),
    .done_o     (done),
    .busy_o     (busy),
    .level_o    (level)
  );

  // Waveform monitor, sampled mid-cycle so every register has settled
  always @(negedge clk) begin
    if (!nRst) begin
      prevInt  = 1'b0;
      prevData = extData;
      highRun  = 0;
      lowRun   = 0;
      sawFall  = 1'b0;
    end else begin
      if (extInt && !prevInt) begin
        obsQ.push_back(extData);
        gapQ.push_back(sawFall ? lowRun : -1);
        highRun = 1;
      end else if (extInt) begin
        highRun++;
      end else if (prevInt) begin
        widthQ.push_back(highRun);
        sawFall = 1'b1;
        lowRun  = 1;
      end else begin
        lowRun++;
      end
      if ((extData !== prevData) && !(extInt && !prevInt)) begin
        dataBad++;
      end
      prevInt  = extInt;
      prevData = extData;
    end
  end

  // Absolute safety net in case a bounded wait is itself broken
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [N-1:0] b, output int stalls);
    int tries;
    tries  = 0;
    stalls = 0;
    sData  = b;
    sValid = 1'b1;
    while (!sReady && tries < 100) begin
      checks++;
      if (level !== LW'(DEPTH)) begin
        errors++;
        $display("[TB] FAIL stall_level actual=%0d required=%0d", level, DEPTH);
      end
      stalls++;
      tries++;
      cycle();
    end
    checks++;
    if (!sReady) begin
      errors++;
      $display("[TB] FAIL push_timeout actual=ready_low required=ready_high");
    end
    cycle();
    sValid = 1'b0;
  endtask

  task automatic waitPulses(input int target, input int maxCyc);
    int n;
    n = 0;
    while (obsQ.size() < target && n < maxCyc) begin
      cycle();
      n++;
    end
    checks++;
    if (obsQ.size() < target) begin
      errors++;
      $display("[TB] FAIL pulse_timeout actual=%0d required=%0d", obsQ.size(), target);
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    cycle();
    cycle();
    checks++;
    if (extData !== '0) begin errors++; $display("[TB] FAIL rst_ext_data actual=%h required=00", extData); end
    checks++;
    if (extInt !== 1'b0) begin errors++; $display("[TB] FAIL rst_ext_int actual=%b required=0", extInt); end
    checks++;
    if (resultOut !== '0) begin errors++; $display("[TB] FAIL rst_result actual=%h required=00", resultOut); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done actual=%b required=0", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy actual=%b required=0", busy); end
    checks++;
    if (level !== '0) begin errors++; $display("[TB] FAIL rst_level actual=%0d required=0", level); end
    nRst = 1'b1;
    repeat (5) cycle();
    checks++;
    if (sReady !== 1'b1) begin errors++; $display("[TB] FAIL rel_ready actual=%b required=1", sReady); end
    checks++;
    if (level !== '0) begin errors++; $display("[TB] FAIL rel_level actual=%0d required=0", level); end
    checks++;
    if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL rel_no_pulse actual=%0d required=0", obsQ.size()); end
  endtask

  task automatic test_single();
    int s0, w0, busyCnt, stalls;
    s0 = obsQ.size();
    w0 = widthQ.size();
    busyCnt = 0;
    pushByte(8'h5A, stalls);
    checks++;
    if (level !== LW'(1)) begin errors++; $display("[TB] FAIL single_level_push actual=%0d required=1", level); end
    checks++;
    if (extInt !== 1'b0) begin errors++; $display("[TB] FAIL single_int_early actual=%b required=0", extInt); end
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) begin
        checks++;
        if (extInt !== 1'b1 || extData !== 8'h5A) begin
          errors++;
          $display("[TB] FAIL single_first_word actual=%b/%h required=1/5a", extInt, extData);
        end
      end
      if (busy === 1'b1) busyCnt++;
    end
    checks++;
    if (busyCnt != INT_HIGH + HOLD) begin errors++; $display("[TB] FAIL single_busy_len actual=%0d required=%0d", busyCnt, INT_HIGH + HOLD); end
    checks++;
    if (obsQ.size() != s0 + 1) begin
      errors++;
      $display("[TB] FAIL single_pulse_count actual=%0d required=1", obsQ.size() - s0);
    end else if (obsQ[s0] !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL single_data actual=%h required=5a", obsQ[s0]);
    end
    checks++;
    if (widthQ.size() != w0 + 1 || widthQ[w0] != INT_HIGH) begin
      errors++;
      $display("[TB] FAIL single_width actual=%0d required=%0d", (widthQ.size() > w0) ? widthQ[w0] : -1, INT_HIGH);
    end
    checks++;
    if (level !== '0) begin errors++; $display("[TB] FAIL single_level_end actual=%0d required=0", level); end
  endtask

  // Shared by back-to-back and random scenarios: delivered order, widths, gaps
  task automatic test_stream(input string name, input logic [N-1:0] bytes[$], input int maxIdle);
    int s0, w0, d0, stalls, totalStalls, got;
    s0 = obsQ.size();
    w0 = widthQ.size();
    d0 = dataBad;
    totalStalls = 0;
    foreach (bytes[i]) begin
      pushByte(bytes[i], stalls);
      totalStalls += stalls;
      if (maxIdle > 0) repeat ($urandom_range(0, maxIdle)) cycle();
    end
    if (maxIdle == 0) begin
      checks++;
      if (totalStalls == 0) begin errors++; $display("[TB] FAIL %s_full_stall actual=0 required=>0", name); end
    end
    waitPulses(s0 + bytes.size(), 60 * bytes.size());
    repeat (INT_HIGH + HOLD + 2) cycle();
    got = obsQ.size() - s0;
    if (got > bytes.size()) got = bytes.size();
    for (int k = 0; k < got; k++) begin
      checks++;
      if (obsQ[s0 + k] !== bytes[k]) begin
        errors++;
        $display("[TB] FAIL %s_order[%0d] actual=%h required=%h", name, k, obsQ[s0 + k], bytes[k]);
      end
      checks++;
      if (widthQ.size() <= w0 + k || widthQ[w0 + k] != INT_HIGH) begin
        errors++;
        $display("[TB] FAIL %s_width[%0d] actual=%0d required=%0d", name, k,
                 (widthQ.size() > w0 + k) ? widthQ[w0 + k] : -1, INT_HIGH);
      end
      if (k > 0) begin
        checks++;
        if (gapQ[s0 + k] < HOLD || (maxIdle == 0 && gapQ[s0 + k] > HOLD + 1)) begin
          errors++;
          $display("[TB] FAIL %s_gap[%0d] actual=%0d required=%0d..%0d", name, k, gapQ[s0 + k], HOLD, HOLD + 1);
        end
      end
    end
    checks++;
    if (dataBad != d0) begin errors++; $display("[TB] FAIL %s_data_stable actual=%0d required=0", name, dataBad - d0); end
    checks++;
    if (level !== '0) begin errors++; $display("[TB] FAIL %s_level_end actual=%0d required=0", name, level); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] bytes[$];
    for (int i = 1; i <= 6; i++) bytes.push_back(N'(i));
    test_stream("b2b", bytes, 0);
  endtask

  task automatic test_random();
    logic [N-1:0] bytes[$];
    for (int i = 0; i < 16; i++) bytes.push_back(N'($urandom));
    test_stream("rand", bytes, 14);
  endtask

  task automatic test_halt_hold();
    logic [N-1:0] b1, b2, b3;
    int s0, stalls, n;
    b1 = N'($urandom);
    b2 = N'($urandom);
    b3 = N'($urandom);
    s0 = obsQ.size();
    pushByte(b1, stalls);
    pushByte(b2, stalls);
    pushByte(b3, stalls);
    n = 0;
    while (extInt === 1'b1 && n < 20) begin cycle(); n++; end
    repeat (3) cycle();
    checks++;
    if (level !== LW'(2) || busy !== 1'b1 || extInt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_pre actual=lvl%0d/busy%b/int%b required=lvl2/busy1/int0", level, busy, extInt);
    end
    halt = 1'b1;
    resultIn = 8'hFD;
    cycle();
    halt = 1'b0;
    resultIn = N'($urandom);
    checks++;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL halt_done actual=%b required=1", done); end
    checks++;
    if (resultOut !== 8'hFD) begin errors++; $display("[TB] FAIL halt_result actual=%h required=fd", resultOut); end
    checks++;
    if (extInt !== 1'b0) begin errors++; $display("[TB] FAIL halt_int actual=%b required=0", extInt); end
    checks++;
    if (sReady !== 1'b0) begin errors++; $display("[TB] FAIL halt_ready actual=%b required=0", sReady); end
    sValid = 1'b1;
    sData = N'($urandom);
    repeat (30) cycle();
    sValid = 1'b0;
    checks++;
    if (obsQ.size() != s0 + 1) begin errors++; $display("[TB] FAIL halt_no_pulse actual=%0d required=1", obsQ.size() - s0); end
    checks++;
    if (level !== LW'(2)) begin errors++; $display("[TB] FAIL halt_level actual=%0d required=2", level); end
    checks++;
    if (extData !== b1 || resultOut !== 8'hFD || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL halt_hold_state actual=%h/%h/%b required=%h/fd/1", extData, resultOut, done, b1);
    end
  endtask

  task automatic test_reset_mid_int();
    int stalls;
    nRst = 1'b0;
    cycle();
    cycle();
    nRst = 1'b1;
    cycle();
    pushByte(N'($urandom_range(1, 255)), stalls);
    pushByte(N'($urandom), stalls);
    checks++;
    if (extInt !== 1'b1) begin errors++; $display("[TB] FAIL rstint_pre actual=%b required=1", extInt); end
    #2;
    nRst = 1'b0;
    #1;
    checks++;
    if (extInt !== 1'b0) begin errors++; $display("[TB] FAIL rstint_int actual=%b required=0", extInt); end
    checks++;
    if (extData !== '0) begin errors++; $display("[TB] FAIL rstint_data actual=%h required=00", extData); end
    checks++;
    if (level !== '0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstint_fifo actual=lvl%0d/busy%b required=lvl0/busy0", level, busy);
    end
    cycle();
    cycle();
    nRst = 1'b1;
    cycle();
    checks++;
    if (sReady !== 1'b1 || level !== '0) begin
      errors++;
      $display("[TB] FAIL rstint_release actual=rdy%b/lvl%0d required=rdy1/lvl0", sReady, level);
    end
  endtask

  task automatic test_halt_idle();
    logic [N-1:0] r;
    int s0, stalls;
    r = N'($urandom);
    s0 = obsQ.size();
    pushByte(N'($urandom), stalls);
    halt = 1'b1;
    resultIn = r;
    cycle();
    halt = 1'b0;
    checks++;
    if (done !== 1'b1 || resultOut !== r) begin
      errors++;
      $display("[TB] FAIL idlehalt_done actual=%b/%h required=1/%h", done, resultOut, r);
    end
    checks++;
    if (extData !== '0 || extInt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idlehalt_no_pop actual=%h/%b required=00/0", extData, extInt);
    end
    repeat (15) cycle();
    checks++;
    if (level !== LW'(1) || obsQ.size() != s0) begin
      errors++;
      $display("[TB] FAIL idlehalt_queued actual=lvl%0d/pulses%0d required=lvl1/pulses0", level, obsQ.size() - s0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_halt_hold();
    test_reset_mid_int();
    test_halt_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
